// File: rtl/acct_prog_master.sv
// Programs NB_WORDS access-control words over AXI4-Lite, reads each one back,
// and reports done or the first failure (bad response, mismatch, timeout).
//
// state | meaning
// IDLE  | waiting for start_i; error flags held
// WR    | AW and W issued together, each dropped after its own handshake
// WRESP | waiting for the B response of the current word
// RD    | AR issued for the current word
// RRESP | waiting for read data, compared against the programmed word
// FIN   | one-cycle done pulse, then back to IDLE
`timescale 1ns/1ps
module acct_prog_master #(
  parameter int unsigned                AXI_ADDR_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter int unsigned                NB_WORDS       = 3,
  parameter int unsigned                TIMEOUT        = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [32*NB_WORDS-1:0]       cfg_i,
  output logic [AXI_ADDR_WIDTH-1:0]    awaddr_o,
  output logic                         awvalid_o,
  input  logic                         awready_i,
  output logic [63:0]                  wdata_o,
  output logic [7:0]                   wstrb_o,
  output logic                         wvalid_o,
  input  logic                         wready_i,
  input  logic [1:0]                   bresp_i,
  input  logic                         bvalid_i,
  output logic                         bready_o,
  output logic [AXI_ADDR_WIDTH-1:0]    araddr_o,
  output logic                         arvalid_o,
  input  logic                         arready_i,
  input  logic [63:0]                  rdata_i,
  input  logic [1:0]                   rresp_i,
  input  logic                         rvalid_i,
  output logic                         rready_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [1:0]                   err_code_o,
  output logic [2:0]                   err_idx_o
);

  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT - 1);
  localparam logic [2:0] LAST_IDX = 3'(NB_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RRESP, FIN} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [7:0]              tmr_q, tmr_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    err_q, err_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [2:0]              err_idx_q, err_idx_d;
  logic [7:0][31:0]        cfg_q, cfg_d, cfg_in;
  logic                    fail;
  logic [1:0]              fail_code;
  logic                    aw_hs, w_hs;
  logic [31:0]             cur_word;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr;
  logic                    unused_rdata_hi;

  for (genvar g = 0; g < 8; g++) begin : g_cfg
    if (g < NB_WORDS) begin : g_used
      assign cfg_in[g] = cfg_i[32*g +: 32];
    end else begin : g_pad
      assign cfg_in[g] = '0;
    end
  end

  assign cur_word        = cfg_q[idx_q];
  assign cur_addr        = BASE_ADDR + AXI_ADDR_WIDTH'({idx_q, 3'b000});
  assign unused_rdata_hi = ^rdata_i[63:32];

  assign awvalid_o  = (state_q == WR) && !aw_done_q;
  assign wvalid_o   = (state_q == WR) && !w_done_q;
  assign awaddr_o   = awvalid_o ? cur_addr : '0;
  assign wdata_o    = wvalid_o ? {32'h0, cur_word} : 64'h0;
  assign wstrb_o    = wvalid_o ? 8'h0F : 8'h00;
  assign bready_o   = (state_q == WRESP);
  assign arvalid_o  = (state_q == RD);
  assign araddr_o   = arvalid_o ? cur_addr : '0;
  assign rready_o   = (state_q == RRESP);
  assign busy_o     = (state_q == WR) || (state_q == WRESP) ||
                      (state_q == RD) || (state_q == RRESP);
  assign done_o     = (state_q == FIN);
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign err_idx_o  = err_idx_q;

  assign aw_hs = awvalid_o && awready_i;
  assign w_hs  = wvalid_o && wready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tmr_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      err_idx_q  <= '0;
      cfg_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
      cfg_q      <= cfg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    cfg_d      = cfg_q;
    fail       = 1'b0;
    fail_code  = 2'b00;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = WR;
          idx_d      = '0;
          tmr_d      = TMR_LOAD;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          err_d      = 1'b0;
          err_code_d = 2'b00;
          err_idx_d  = '0;
          cfg_d      = cfg_in;
        end
      end
      WR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = WRESP;
          tmr_d   = TMR_LOAD;
        end else if (aw_hs || w_hs) begin
          tmr_d = TMR_LOAD;
        end else if (tmr_q == 8'd0) begin
          fail      = 1'b1;
          fail_code = 2'b11;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      WRESP: begin
        if (bvalid_i) begin
          if (bresp_i != 2'b00) begin
            fail      = 1'b1;
            fail_code = 2'b01;
          end else begin
            state_d = RD;
            tmr_d   = TMR_LOAD;
          end
        end else if (tmr_q == 8'd0) begin
          fail      = 1'b1;
          fail_code = 2'b11;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      RD: begin
        if (arready_i) begin
          state_d = RRESP;
          tmr_d   = TMR_LOAD;
        end else if (tmr_q == 8'd0) begin
          fail      = 1'b1;
          fail_code = 2'b11;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      RRESP: begin
        if (rvalid_i) begin
          if (rresp_i != 2'b00) begin
            fail      = 1'b1;
            fail_code = 2'b01;
          end else if (rdata_i[31:0] != cur_word) begin
            fail      = 1'b1;
            fail_code = 2'b10;
          end else if (idx_q == LAST_IDX) begin
            state_d = FIN;
          end else begin
            // next word starts with a fresh write; its read waits for its B
            state_d   = WR;
            idx_d     = idx_q + 3'd1;
            tmr_d     = TMR_LOAD;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end
        end else if (tmr_q == 8'd0) begin
          fail      = 1'b1;
          fail_code = 2'b11;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fail) begin
      state_d    = IDLE;
      err_d      = 1'b1;
      err_code_d = fail_code;
      err_idx_d  = idx_q;
    end
  end

endmodule

// File: tb/tb_acct_prog_master.sv
// Bench for acct_prog_master: a table of passes run against a reactive AXI-Lite
// slave model, with a scoreboard of expected AW/W/AR beats.
`timescale 1ns/1ps
module tb_acct_prog_master;

  localparam int NW = 3;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [32*NW-1:0]  cfg_i;
  logic [63:0]       awaddr_o;
  logic              awvalid_o;
  logic              awready_i;
  logic [63:0]       wdata_o;
  logic [7:0]        wstrb_o;
  logic              wvalid_o;
  logic              wready_i;
  logic [1:0]        bresp_i;
  logic              bvalid_i;
  logic              bready_o;
  logic [63:0]       araddr_o;
  logic              arvalid_o;
  logic              arready_i;
  logic [63:0]       rdata_i;
  logic [1:0]        rresp_i;
  logic              rvalid_i;
  logic              rready_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [1:0]        err_code_o;
  logic [2:0]        err_idx_o;

  always #5 clk_i = ~clk_i;

  acct_prog_master #(
    .AXI_ADDR_WIDTH (64),
    .BASE_ADDR      (64'h0),
    .NB_WORDS       (NW),
    .TIMEOUT        (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .cfg_i      (cfg_i),
    .awaddr_o   (awaddr_o),
    .awvalid_o  (awvalid_o),
    .awready_i  (awready_i),
    .wdata_o    (wdata_o),
    .wstrb_o    (wstrb_o),
    .wvalid_o   (wvalid_o),
    .wready_i   (wready_i),
    .bresp_i    (bresp_i),
    .bvalid_i   (bvalid_i),
    .bready_o   (bready_o),
    .araddr_o   (araddr_o),
    .arvalid_o  (arvalid_o),
    .arready_i  (arready_i),
    .rdata_i    (rdata_i),
    .rresp_i    (rresp_i),
    .rvalid_i   (rvalid_i),
    .rready_o   (rready_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .err_idx_o  (err_idx_o)
  );

  typedef struct {
    logic [95:0] cfg;
    int          aw_delay;
    int          w_delay;
    bit          aw_never;
    bit          w_never;
    int          bad_b;
    int          lock;
    logic [1:0]  exp_code;
    logic [2:0]  exp_idx;
    int          exp_busy;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // slave configuration and state
  int          aw_delay, w_delay, bad_b_idx, lock_idx;
  bit          aw_never, w_never;
  int          aw_wait, w_wait;
  bit          aw_hs_f, w_hs_f, b_hs_f, ar_hs_f, r_hs_f;
  int          n_aw, n_w, n_b, n_ar;
  bit          r_pend;
  logic [63:0] last_awaddr, last_araddr;
  logic [31:0] last_wdata;
  logic [31:0] mem [8];
  bit          prev_awvalid, prev_wvalid, prev_arvalid;
  logic [63:0] prev_awaddr, prev_wdata, prev_araddr;
  int          done_cnt, busy_cnt, act_cnt;
  logic [63:0] exp_aw_q[$];
  logic [63:0] exp_w_q[$];
  logic [63:0] exp_ar_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: beat seen, none expected", name);
  endtask

  task automatic slave_clear();
    awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
    arready_i = 0; rvalid_i = 0; rdata_i = 0; rresp_i = 0;
    aw_wait = 0; w_wait = 0;
    aw_hs_f = 0; w_hs_f = 0; b_hs_f = 0; ar_hs_f = 0; r_hs_f = 0;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; r_pend = 0;
    last_awaddr = 0; last_araddr = 0; last_wdata = 0;
    prev_awvalid = 0; prev_wvalid = 0; prev_arvalid = 0;
    prev_awaddr = 0; prev_wdata = 0; prev_araddr = 0;
    done_cnt = 0; busy_cnt = 0; act_cnt = 0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
  endtask

  // Called once per falling edge: retires the beats of the last rising edge,
  // checks AXI stability, then chooses the inputs for the next rising edge.
  task automatic slave_step();
    if (aw_hs_f) n_aw++;
    if (w_hs_f)  n_w++;
    if (b_hs_f) begin bvalid_i = 0; n_b++; end
    if (ar_hs_f) begin n_ar++; r_pend = 1; end
    if (r_hs_f)  rvalid_i = 0;

    if (prev_awvalid && !aw_hs_f && !err_o) begin
      check("aw held", {63'h0, awvalid_o}, 64'h1);
      if (awvalid_o) check("aw addr stable", awaddr_o, prev_awaddr);
    end
    if (prev_wvalid && !w_hs_f && !err_o) begin
      check("w held", {63'h0, wvalid_o}, 64'h1);
      if (wvalid_o) check("w data stable", wdata_o, prev_wdata);
    end
    if (prev_arvalid && !ar_hs_f && !err_o) begin
      check("ar held", {63'h0, arvalid_o}, 64'h1);
      if (arvalid_o) check("ar addr stable", araddr_o, prev_araddr);
    end

    if (done_o) done_cnt++;
    if (busy_o) busy_cnt++;
    if (awvalid_o || wvalid_o || bready_o || arvalid_o || rready_o) act_cnt++;

    if (awvalid_o) begin
      awready_i = !aw_never && (aw_wait >= aw_delay);
      aw_wait++;
    end else begin
      awready_i = 0;
      aw_wait = 0;
    end
    aw_hs_f = awvalid_o && awready_i;
    if (aw_hs_f) begin
      aw_wait = 0;
      last_awaddr = awaddr_o;
      if (exp_aw_q.size() == 0) unexpected("aw beat");
      else check("aw addr", awaddr_o, exp_aw_q.pop_front());
    end

    if (wvalid_o) begin
      wready_i = !w_never && (w_wait >= w_delay);
      w_wait++;
    end else begin
      wready_i = 0;
      w_wait = 0;
    end
    w_hs_f = wvalid_o && wready_i;
    if (w_hs_f) begin
      w_wait = 0;
      last_wdata = wdata_o[31:0];
      check("w strb", {56'h0, wstrb_o}, 64'h0F);
      if (exp_w_q.size() == 0) unexpected("w beat");
      else check("w data", wdata_o, exp_w_q.pop_front());
    end

    if (!bvalid_i && n_aw > n_b && n_w > n_b) begin
      bvalid_i = 1;
      bresp_i  = (n_b == bad_b_idx) ? 2'b10 : 2'b00;
      mem[last_awaddr[5:3]] = last_wdata;
    end
    b_hs_f = bvalid_i && bready_o;

    arready_i = arvalid_o;
    ar_hs_f = arvalid_o && arready_i;
    if (ar_hs_f) begin
      last_araddr = araddr_o;
      if (exp_ar_q.size() == 0) unexpected("ar beat");
      else check("ar addr", araddr_o, exp_ar_q.pop_front());
    end

    if (r_pend && !rvalid_i) begin
      rvalid_i = 1;
      rresp_i  = 2'b00;
      rdata_i  = {32'hA5A5_A5A5,
                  (lock_idx == int'(last_araddr[5:3])) ? 32'h0 : mem[last_araddr[5:3]]};
      r_pend   = 0;
    end
    r_hs_f = rvalid_i && rready_o;

    prev_awvalid = awvalid_o; prev_awaddr = awaddr_o;
    prev_wvalid  = wvalid_o;  prev_wdata  = wdata_o;
    prev_arvalid = arvalid_o; prev_araddr = araddr_o;
  endtask

  task automatic tick();
    @(negedge clk_i);
    slave_step();
  endtask

  task automatic push_expected(input logic [95:0] cfg, input int n_wr, input int n_rd);
    logic [31:0] w;
    for (int i = 0; i < n_wr; i++) begin
      w = cfg[32*i +: 32];
      exp_aw_q.push_back(64'(8 * i));
      exp_w_q.push_back({32'h0, w});
    end
    for (int i = 0; i < n_rd; i++) exp_ar_q.push_back(64'(8 * i));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n_wr, n_rd;
    slave_clear();
    aw_delay = v.aw_delay; w_delay = v.w_delay;
    aw_never = v.aw_never; w_never = v.w_never;
    bad_b_idx = v.bad_b;   lock_idx = v.lock;
    case (v.exp_code)
      2'b00:   begin n_wr = NW;               n_rd = NW;               end
      2'b01:   begin n_wr = int'(v.exp_idx) + 1; n_rd = int'(v.exp_idx);     end
      2'b10:   begin n_wr = int'(v.exp_idx) + 1; n_rd = int'(v.exp_idx) + 1; end
      default: begin n_wr = 0;                n_rd = 0;                end
    endcase
    push_expected(v.cfg, n_wr, n_rd);

    cfg_i   = v.cfg;
    start_i = 1;
    tick();
    start_i = 0;
    cfg_i   = ~v.cfg;
    for (int c = 0; c < 400 && done_cnt == 0 && !err_o; c++) tick();
    if (done_cnt == 0 && !err_o) begin
      checks++;
      errors++;
      $display("FAIL %s end: no done_o or err_o within 400 cycles", tag);
    end
    tick();
    tick();

    check($sformatf("%s err_o", tag), {63'h0, err_o}, {63'h0, v.exp_code != 2'b00});
    check($sformatf("%s err_code", tag), {62'h0, err_code_o}, {62'h0, v.exp_code});
    check($sformatf("%s err_idx", tag), {61'h0, err_idx_o}, {61'h0, v.exp_idx});
    check($sformatf("%s done pulses", tag), 64'(done_cnt), (v.exp_code == 2'b00) ? 64'h1 : 64'h0);
    check($sformatf("%s busy cycles", tag), 64'(busy_cnt), 64'(v.exp_busy));
    check($sformatf("%s beats missing", tag),
          64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 64'h0);
    check($sformatf("%s idle outputs", tag),
          {58'h0, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, busy_o}, 64'h0);
  endtask

  function automatic vec_t mk(input logic [95:0] cfg, input int awd, input int wd,
                              input bit awn, input bit wn, input int bb, input int lk,
                              input logic [1:0] code, input logic [2:0] idx, input int bsy);
    vec_t v;
    v.cfg = cfg; v.aw_delay = awd; v.w_delay = wd; v.aw_never = awn; v.w_never = wn;
    v.bad_b = bb; v.lock = lk; v.exp_code = code; v.exp_idx = idx; v.exp_busy = bsy;
    return v;
  endfunction

  initial begin
    vec_t vecs[7];
    vecs[0] = mk({32'hC, 32'hB, 32'hA},                      0, 0, 0, 0, -1, -1, 2'b00, 3'd0, 12);
    vecs[1] = mk({32'h3333_0003, 32'h2222_0002, 32'h1111_0001}, 3, 0, 0, 0, -1, -1, 2'b00, 3'd0, 21);
    vecs[2] = mk({32'h8000_0001, 32'h0F0F_F0F0, 32'h1234_5678}, 0, 2, 0, 0, -1, -1, 2'b00, 3'd0, 18);
    vecs[3] = mk({32'h0000_00C3, 32'h0000_00B2, 32'h0000_00A1}, 0, 0, 0, 0, -1,  1, 2'b10, 3'd1, 8);
    vecs[4] = mk({32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000}, 0, 0, 0, 0,  2, -1, 2'b01, 3'd2, 10);
    vecs[5] = mk({32'h5, 32'h6, 32'h7},                      0, 0, 1, 1, -1, -1, 2'b11, 3'd0, 16);
    vecs[6] = mk({32'hFFFF_FFFF, 32'h7FFF_FFFE, 32'h0000_0001}, 0, 0, 0, 0, -1, -1, 2'b00, 3'd0, 12);

    rst_i   = 1;
    start_i = 0;
    cfg_i   = '0;
    aw_delay = 0; w_delay = 0; aw_never = 0; w_never = 0; bad_b_idx = -1; lock_idx = -1;
    slave_clear();
    repeat (3) @(negedge clk_i);
    check("reset busy_o", {63'h0, busy_o}, 64'h0);
    check("reset done_o", {63'h0, done_o}, 64'h0);
    check("reset err", {60'h0, err_o, err_code_o, err_idx_o[0]}, 64'h0);
    check("reset valids", {59'h0, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o}, 64'h0);
    check("reset addr/data", awaddr_o | araddr_o | wdata_o, 64'h0);
    rst_i = 0;
    tick();

    for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("v%0d", k));

    // reset while word 1 is waiting in RRESP, then a fresh full pass
    slave_clear();
    aw_delay = 0; w_delay = 0; aw_never = 0; w_never = 0; bad_b_idx = -1; lock_idx = -1;
    push_expected(vecs[0].cfg, 2, 2);
    cfg_i   = vecs[0].cfg;
    start_i = 1;
    tick();
    start_i = 0;
    for (int c = 0; c < 100 && !(rready_o && n_ar == 2); c++) tick();
    check("mid-pass reached rresp word1", {63'h0, rready_o && n_ar == 2}, 64'h1);
    #2 rst_i = 1;
    #1;
    check("async rst busy/done", {62'h0, busy_o, done_o}, 64'h0);
    check("async rst valids", {59'h0, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o}, 64'h0);
    check("async rst addr", araddr_o | awaddr_o, 64'h0);
    check("mid-pass beats missing", 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 64'h0);
    slave_clear();
    tick();
    rst_i = 0;
    repeat (5) tick();
    check("post-reset activity", 64'(act_cnt), 64'h0);
    check("post-reset done", 64'(done_cnt), 64'h0);
    run_vec(vecs[0], "after-rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acct_prog_master.md
ACCT_PROG_MASTER -- requirements
Module: acct_prog_master

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 64, address width of the AXI4-Lite initiator port.
REQ-002 Parameter BASE_ADDR, default 0, byte address of access-control word 0; word i lives at BASE_ADDR + 8*i.
REQ-003 Parameter NB_WORDS, default 3, number of 32-bit access-control words programmed; range 1..8.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles waited on any single handshake; range 1..255.
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous and active-high.
REQ-007 start_i  in  1  one-cycle pulse requesting a program-and-verify pass.
REQ-008 cfg_i  in  32*NB_WORDS  words to program; word i = cfg_i[32*i+31:32*i].
REQ-009 awaddr_o  out  AXI_ADDR_WIDTH; awvalid_o out 1; awready_i in 1 -- write address channel.
REQ-010 wdata_o  out  64; wstrb_o out 8; wvalid_o out 1; wready_i in 1 -- write data channel.
REQ-011 bresp_i  in  2; bvalid_i in 1; bready_o out 1 -- write response channel.
REQ-012 araddr_o  out  AXI_ADDR_WIDTH; arvalid_o out 1; arready_i in 1 -- read address channel.
REQ-013 rdata_i  in  64; rresp_i in 2; rvalid_i in 1; rready_o out 1 -- read data channel.
REQ-014 busy_o  out  1  pass in progress.
REQ-015 done_o  out  1  one-cycle pulse: all words written and read back equal.
REQ-016 err_o  out  1  sticky error flag, cleared by next accepted start_i.
REQ-017 err_code_o  out  2  01 bad resp, 10 readback mismatch, 11 timeout; 00 when err_o low.
REQ-018 err_idx_o  out  3  index of word that failed; 0 when err_o low.

Function
REQ-019 FSM states SHALL be IDLE, WR, WRESP, RD, RRESP, FIN.
REQ-020 IDLE: start_i high -> WR with index 0, err_o/err_code_o/err_idx_o cleared, busy_o high next cycle; start_i ignored in all other states.
REQ-021 WR: awvalid_o and wvalid_o asserted together, awaddr_o = BASE_ADDR+8*idx, wdata_o = {32'h0, word idx}, wstrb_o = 8'h0F.
REQ-022 AW and W handshakes are tracked independently; each valid drops the cycle after its own ready is sampled; leave WR when both accepted (same or different cycles).
REQ-023 WRESP: bready_o high; on bvalid_i, bresp_i != 2'b00 -> error 01, else -> RD.
REQ-024 RD: arvalid_o high, araddr_o = BASE_ADDR+8*idx, until arready_i; then RRESP.
REQ-025 RRESP: rready_o high; on rvalid_i, rresp_i != 00 -> error 01; rdata_i[31:0] != word idx -> error 10; else idx+1, or FIN after idx = NB_WORDS-1.
REQ-026 FIN: done_o pulses one cycle, busy_o drops, return to IDLE.
REQ-027 Timeout counter resets on every state entry and on every handshake; reaching TIMEOUT in WR/WRESP/RD/RRESP -> error 11.
REQ-028 Any error: err_o set, err_code_o and err_idx_o captured, all valid/ready outputs low next cycle, busy_o low, return to IDLE; done_o not asserted.
REQ-029 Valid outputs, once raised, SHALL stay high and their address/data stable until the matching ready (AXI rule), except on reset.
REQ-030 No more than one write and one read outstanding; the read for word i is issued only after its B response.
REQ-031 cfg_i is sampled once into an internal register on the accepted start_i; later changes do not affect the pass.

Reset
REQ-032 rst_i high asynchronously forces IDLE, idx 0, counter 0, all valid/ready outputs, busy_o, done_o, err_o low, err_code_o/err_idx_o 0, addresses/data 0.
REQ-033 Reset asserted mid-pass abandons the pass immediately; no done_o is produced and no further channel activity follows.

Verification
REQ-034 NB_WORDS=3, cfg_i=96'hC/B/A words, slave always ready, OKAY, echoes writes -> three writes to 0x0/0x8/0x10, three matching reads, done_o single pulse, err_o 0.
REQ-035 Slave raises wready_i 3 cycles before awready_i -> wvalid_o drops after W handshake, awvalid_o held stable with 0x8 until accepted, pass completes.
REQ-036 Slave returns rdata 0 for word 1 (read-locked) -> err_o 1, err_code_o 10, err_idx_o 1, no done_o, outputs idle.
REQ-037 bresp_i=2'b10 on word 2 -> err_code_o 01, err_idx_o 2; awready_i never asserted with TIMEOUT=16 -> err_code_o 11 after 16 cycles.
REQ-038 rst_i pulsed during RRESP of word 1 -> all outputs 0 in same cycle (async), then fresh start_i completes a full pass.
